// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one asynchronous-FIFO write port among NUM_REQ
// requesters in the write clock domain. A grant lasts up to BURST_MAX beats,
// or ends early on the owner's last beat or when the owner drops its request.
// On release the next owner is picked in the same cycle, so there is no idle
// bubble between bursts. A full FIFO stalls the owner without preemption.
module fifo_wr_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4,
    parameter int OWN_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          wr_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          busy,
    output logic [OWN_W-1:0]              owner
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_MAX - 1);
    localparam logic [OWN_W-1:0] OWNER_INIT = OWN_W'(NUM_REQ - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]         state;
    logic [OWN_W-1:0]   last_owner;
    logic [CNT_W-1:0]   beat_cnt;

    logic               owner_req;
    logic               owner_last;
    logic               beat_ok;
    logic               release_now;
    logic [NUM_REQ-1:0] rel_req;

    logic               idle_hit;
    logic [OWN_W-1:0]   idle_win;
    logic               rel_hit;
    logic [OWN_W-1:0]   rel_win;

    // Round-robin pick: first set bit of r scanning upward from after+1, wrapping.
    // Returns {hit, index}.
    function automatic logic [OWN_W:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [OWN_W-1:0]   after
    );
        logic             hit;
        logic [OWN_W-1:0] win;
        int unsigned      idx;
        hit = 1'b0;
        win = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(after) + k) % NUM_REQ;
            if (!hit && r[idx]) begin
                hit = 1'b1;
                win = OWN_W'(idx);
            end
        end
        return {hit, win};
    endfunction

    // Owner-side views of the request vectors and the release decision.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == OWN_W'(i)) begin
                owner_req  = req[i];
                owner_last = req_last[i];
            end
        end
        beat_ok     = (state == ST_OWN) && owner_req && !wr_full;
        release_now = (state == ST_OWN) &&
                      ((beat_ok && (owner_last || beat_cnt == LAST_BEAT)) || !owner_req);
    end

    // Arbitration candidates: from IDLE the scan follows last_owner; on release
    // the releasing owner becomes last_owner and is masked out for this pick.
    always_comb begin
        rel_req = req;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == OWN_W'(i)) begin
                rel_req[i] = 1'b0;
            end
        end
        {idle_hit, idle_win} = rr_pick(req, last_owner);
        {rel_hit, rel_win}   = rr_pick(rel_req, owner);
    end

    // Write-port mux: ack only the owner's beat when the FIFO has room.
    always_comb begin
        ack     = '0;
        wr_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (state == ST_OWN && owner == OWN_W'(i)) begin
                ack[i]  = beat_ok;
                wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        wr_en = |ack;
        busy  = (state == ST_OWN);
    end

    // Grant state machine, owner tracking and per-burst beat counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= OWNER_INIT;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_hit) begin
                        state    <= ST_OWN;
                        owner    <= idle_win;
                        beat_cnt <= '0;
                    end
                end
                ST_OWN: begin
                    if (release_now) begin
                        last_owner <= owner;
                        beat_cnt   <= '0;
                        if (rel_hit) begin
                            owner <= rel_win;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (beat_ok) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with the default parameters (8-bit data,
// 4 requesters, 4-beat bursts). Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_fifo_wr_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        wr_full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    fifo_wr_arb #(
        .DATA_WIDTH(8),
        .NUM_REQ   (4),
        .BURST_MAX (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .req_last(req_last),
        .ack     (ack),
        .wr_full (wr_full),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .busy    (busy),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic tick_in();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        req      = '0;
        req_data = '0;
        req_last = '0;
        wr_full  = 1'b0;

        // Reset state
        #12;
        check("rst_busy",  32'(busy), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_ack",   32'(ack), 0);
        check("rst_wdata", 32'(wr_data), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_lastown", 32'(dut.last_owner), 3);
        check("rst_beatcnt", 32'(dut.beat_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        // Single requester 2, three beats ending with req_last
        tick_in(); req = 4'b0100; set_data(2, 8'hA1); #1;
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_wren", 32'(wr_en), 0);
        tick_in(); #1;
        check("t1_b1_busy", 32'(busy), 1);
        check("t1_b1_owner", 32'(owner), 2);
        check("t1_b1_ack", 32'(ack), 32'h4);
        check("t1_b1_data", 32'(wr_data), 32'hA1);
        tick_in(); set_data(2, 8'hA2); #1;
        check("t1_b2_wren", 32'(wr_en), 1);
        check("t1_b2_data", 32'(wr_data), 32'hA2);
        tick_in(); set_data(2, 8'hA3); req_last = 4'b0100; #1;
        check("t1_b3_ack", 32'(ack), 32'h4);
        check("t1_b3_data", 32'(wr_data), 32'hA3);
        tick_in(); req = '0; req_last = '0; #1;
        check("t1_end_busy", 32'(busy), 0);
        check("t1_end_wren", 32'(wr_en), 0);
        check("t1_end_lastown", 32'(dut.last_owner), 2);

        // Requesters 0 and 1 held: alternating 4-beat bursts with no gaps
        tick_in(); req = 4'b0011; set_data(0, 8'h10); set_data(1, 8'h20); #1;
        check("t2_idle_wren", 32'(wr_en), 0);
        for (int b = 0; b < 16; b++) begin
            int eo;
            eo = (b / 4) % 2;
            tick_in(); #1;
            check("t2_owner", 32'(owner), 32'(eo));
            check("t2_wren", 32'(wr_en), 1);
            check("t2_ack", 32'(ack), (eo == 0) ? 32'h1 : 32'h2);
            check("t2_data", 32'(wr_data), (eo == 0) ? 32'h10 : 32'h20);
        end
        tick_in(); req = '0; #1;
        check("t2_drop_owner", 32'(owner), 0);
        check("t2_drop_busy", 32'(busy), 1);
        check("t2_drop_wren", 32'(wr_en), 0);
        tick_in(); #1;
        check("t2_end_busy", 32'(busy), 0);

        // All four at once after reset, one beat each: order 0,1,2,3
        do_reset();
        req = 4'b1111; req_last = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'hB0 + 8'(i));
        #1;
        check("t3_idle_wren", 32'(wr_en), 0);
        for (int k = 0; k < 4; k++) begin
            tick_in();
            if (k > 0) req[k-1] = 1'b0;
            #1;
            check("t3_owner", 32'(owner), 32'(k));
            check("t3_ack", 32'(ack), 32'(1 << k));
            check("t3_data", 32'(wr_data), 32'hB0 + 32'(k));
        end
        tick_in(); req = '0; req_last = '0; #1;
        check("t3_end_busy", 32'(busy), 0);

        // Requester 1 stalled by wr_full for 3 cycles after beat 2
        tick_in(); req = 4'b0010; set_data(1, 8'hC1); #1;
        check("t4_idle_wren", 32'(wr_en), 0);
        tick_in(); #1;
        check("t4_b1_data", 32'(wr_data), 32'hC1);
        tick_in(); set_data(1, 8'hC2); #1;
        check("t4_b2_ack", 32'(ack), 32'h2);
        for (int s = 0; s < 3; s++) begin
            tick_in(); set_data(1, 8'hC3); wr_full = 1'b1; #1;
            check("t4_stall_ack", 32'(ack), 0);
            check("t4_stall_wren", 32'(wr_en), 0);
            check("t4_stall_owner", 32'(owner), 1);
            check("t4_stall_cnt", 32'(dut.beat_cnt), 2);
        end
        tick_in(); wr_full = 1'b0; #1;
        check("t4_b3_ack", 32'(ack), 32'h2);
        check("t4_b3_data", 32'(wr_data), 32'hC3);
        tick_in(); set_data(1, 8'hC4); #1;
        check("t4_b4_data", 32'(wr_data), 32'hC4);
        check("t4_b4_cnt", 32'(dut.beat_cnt), 3);
        tick_in(); req = '0; #1;
        check("t4_end_busy", 32'(busy), 0);

        // Owner 3 drops after one beat with req 0 pending
        tick_in(); req = 4'b1001; set_data(3, 8'hD1); set_data(0, 8'hE0); #1;
        check("t5_idle_wren", 32'(wr_en), 0);
        tick_in(); #1;
        check("t5_b1_owner", 32'(owner), 3);
        check("t5_b1_ack", 32'(ack), 32'h8);
        tick_in(); req = 4'b0001; #1;
        check("t5_drop_ack", 32'(ack), 0);
        check("t5_drop_wren", 32'(wr_en), 0);
        tick_in(); req_last = 4'b0001; #1;
        check("t5_new_owner", 32'(owner), 0);
        check("t5_lastown", 32'(dut.last_owner), 3);
        check("t5_cnt", 32'(dut.beat_cnt), 0);
        check("t5_new_ack", 32'(ack), 32'h1);
        check("t5_new_data", 32'(wr_data), 32'hE0);
        tick_in(); req = '0; req_last = '0; #1;
        check("t5_end_busy", 32'(busy), 0);

        // Reset mid-burst of requester 2, then 1 and 2 compete
        tick_in(); req = 4'b0100; set_data(2, 8'hF1); #1;
        tick_in(); #1;
        check("t6_b1_ack", 32'(ack), 32'h4);
        tick_in(); rst = 1'b0; #1;
        check("t6_rst_wren", 32'(wr_en), 0);
        check("t6_rst_ack", 32'(ack), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_lastown", 32'(dut.last_owner), 3);
        tick_in(); rst = 1'b1; req = 4'b0110; set_data(1, 8'h71); #1;
        check("t6_idle_busy", 32'(busy), 0);
        tick_in(); #1;
        check("t6_owner", 32'(owner), 1);
        check("t6_ack", 32'(ack), 32'h2);
        check("t6_data", 32'(wr_data), 32'h71);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
